// File: rtl/button_event_pkg.sv
// Shared constants and helpers for the pushbutton event front-end.
package button_event_pkg;

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_DELAY  = 2'd1;
    localparam logic [1:0] ST_REPEAT = 2'd2;

    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++)
            if ((64'd1 << i) < 64'(value)) r = i + 1;
        return r;
    endfunction

    // Index of the lowest set bit; 0 when the vector is empty.
    function automatic int unsigned lowest_idx(input logic [31:0] vec);
        int unsigned idx;
        idx = 0;
        for (int unsigned i = 32; i > 0; i--)
            if (vec[i-1]) idx = i - 1;
        return idx;
    endfunction

endpackage

// File: rtl/sample_tick_gen.sv
// Prescaler producing a one-cycle tick every DIV clock cycles.
module sample_tick_gen
    import button_event_pkg::*;
#(
    parameter int unsigned DIV = 50000
) (
    input  logic clk,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);

    logic [CW-1:0] r_cnt;

    assign tick = (r_cnt == CW'(DIV - 1));

    always_ff @(posedge clk or posedge clr) begin
        if (clr)
            r_cnt <= '0;
        else if (tick)
            r_cnt <= '0;
        else
            r_cnt <= r_cnt + CW'(1);
    end

endmodule

// File: rtl/button_event_ctrl.sv
// Debounces N pushbuttons and merges press/auto-repeat events into one
// valid/ready stream, lowest button index first.
module button_event_ctrl
    import button_event_pkg::*;
#(
    parameter int unsigned N            = 4,
    parameter int unsigned DIV          = 50000,
    parameter int unsigned REPEAT_DELAY = 50,
    parameter int unsigned REPEAT_RATE  = 10,
    localparam int unsigned IDW         = (clog2(N) < 1) ? 1 : clog2(N)
) (
    input  logic           clk,
    input  logic           clr,
    input  logic [N-1:0]   in,
    input  logic           repeat_en,
    output logic [N-1:0]   level,
    output logic           ev_valid,
    input  logic           ev_ready,
    output logic [IDW-1:0] ev_id,
    output logic           ev_repeat,
    output logic           overrun
);

    localparam int unsigned RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned RCW  = (clog2(RMAX) < 1) ? 1 : clog2(RMAX);

    logic           w_tick;
    logic [N-1:0]   r_s0, r_s1, r_lvl;
    logic [N-1:0]   r_pend, r_rpt;
    logic [1:0]     r_state;
    logic [IDW-1:0] r_rep_idx;
    logic [RCW-1:0] r_rep_cnt;
    logic           r_ev_valid, r_ev_repeat, r_overrun;
    logic [IDW-1:0] r_ev_id;

    logic [N-1:0]   w_all, w_rise, w_set_rpt, w_set, w_clr, w_pend_nx, w_rpt_nx;
    logic [1:0]     w_state_nx;
    logic [IDW-1:0] w_idx_nx, w_sel;
    logic [RCW-1:0] w_cnt_nx, w_cmp;
    logic           w_rep_ev, w_load, w_ovr;

    sample_tick_gen #(.DIV(DIV)) u_tick (
        .clk  (clk),
        .clr  (clr),
        .tick (w_tick)
    );

    assign w_all  = in & r_s0 & r_s1;
    assign w_rise = w_tick ? (w_all & ~r_lvl) : '0;
    assign w_cmp  = (r_state == ST_DELAY) ? RCW'(REPEAT_DELAY - 1) : RCW'(REPEAT_RATE - 1);

    // A fresh press always retargets the repeat engine; release beats a due repeat.
    always_comb begin
        w_state_nx = r_state;
        w_idx_nx   = r_rep_idx;
        w_cnt_nx   = r_rep_cnt;
        w_rep_ev   = 1'b0;
        if (w_tick) begin
            if (|w_rise) begin
                w_idx_nx   = IDW'(lowest_idx(32'(w_rise)));
                w_cnt_nx   = '0;
                w_state_nx = ST_DELAY;
            end else if (r_state != ST_IDLE) begin
                if (!w_all[r_rep_idx] || !repeat_en) begin
                    w_state_nx = ST_IDLE;
                end else if (r_rep_cnt == w_cmp) begin
                    w_rep_ev   = 1'b1;
                    w_cnt_nx   = '0;
                    w_state_nx = ST_REPEAT;
                end else begin
                    w_cnt_nx = r_rep_cnt + RCW'(1);
                end
            end
        end
    end

    assign w_set_rpt = w_rep_ev ? (N'(1) << r_rep_idx) : '0;
    assign w_set     = w_rise | w_set_rpt;
    assign w_sel     = IDW'(lowest_idx(32'(r_pend)));
    assign w_load    = (!r_ev_valid || ev_ready) && (|r_pend);
    assign w_clr     = w_load ? (N'(1) << w_sel) : '0;
    assign w_pend_nx = (r_pend & ~w_clr) | w_set;
    assign w_rpt_nx  = (r_rpt & ~w_rise) | w_set_rpt;
    assign w_ovr     = |(w_set & r_pend & ~w_clr);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_s0        <= '0;
            r_s1        <= '0;
            r_lvl       <= '0;
            r_pend      <= '0;
            r_rpt       <= '0;
            r_state     <= ST_IDLE;
            r_rep_idx   <= '0;
            r_rep_cnt   <= '0;
            r_ev_valid  <= 1'b0;
            r_ev_id     <= '0;
            r_ev_repeat <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            if (w_tick) begin
                r_s0  <= in;
                r_s1  <= r_s0;
                r_lvl <= w_all;
            end
            r_pend    <= w_pend_nx;
            r_rpt     <= w_rpt_nx;
            r_overrun <= w_ovr;
            r_state   <= w_state_nx;
            r_rep_idx <= w_idx_nx;
            r_rep_cnt <= w_cnt_nx;
            if (w_load) begin
                r_ev_valid  <= 1'b1;
                r_ev_id     <= w_sel;
                r_ev_repeat <= r_rpt[w_sel];
            end else if (ev_ready) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    assign level     = r_lvl;
    assign ev_valid  = r_ev_valid;
    assign ev_id     = r_ev_id;
    assign ev_repeat = r_ev_repeat;
    assign overrun   = r_overrun;

endmodule

// File: tb/tb_button_event_ctrl.sv
// Self-checking bench for button_event_ctrl: directed scenarios plus random
// stimulus checked cycle by cycle against a behavioural model.
module tb_button_event_ctrl;

    localparam int N  = 4;
    localparam int DV = 4;
    localparam int RD = 3;
    localparam int RR = 2;

    logic       clk, clr, repeat_en, ev_ready;
    logic [3:0] btn, level;
    logic       ev_valid, ev_repeat, overrun;
    logic [1:0] ev_id;

    button_event_ctrl #(.N(N), .DIV(DV), .REPEAT_DELAY(RD), .REPEAT_RATE(RR)) dut (
        .clk       (clk),
        .clr       (clr),
        .in        (btn),
        .repeat_en (repeat_en),
        .level     (level),
        .ev_valid  (ev_valid),
        .ev_ready  (ev_ready),
        .ev_id     (ev_id),
        .ev_repeat (ev_repeat),
        .overrun   (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int cyc; logic [3:0] lvl; logic v; logic [1:0] id; logic rep; } press_vec_t;
    typedef struct { int cyc; logic [1:0] id; logic rep; } ev_t;

    press_vec_t pv[5];
    ev_t        exp_rep[4];
    ev_t        ev_log[$];

    int n_checks = 0, n_fail = 0;
    int cyc = 0, n_valid = 0, n_ovr = 0, n_lvl1 = 0;

    // Behavioural model: consecutive-high tick counts per button, ticks held
    // since the tracked press, and a pending bitmap drained lowest-first.
    int         m_cnt, m_run[4], m_btn, m_held;
    bit         m_active, m_ticked;
    logic [3:0] m_pend, m_rflag;
    logic       m_v, m_rep, m_ovr;
    logic [1:0] m_id;

    function automatic int lowest(input logic [3:0] v);
        int r;
        r = 0;
        for (int i = 3; i >= 0; i--) if (v[i]) r = i;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0; m_btn = 0; m_held = 0; m_active = 0; m_ticked = 0;
        for (int i = 0; i < 4; i++) m_run[i] = 0;
        m_pend = '0; m_rflag = '0; m_v = 0; m_rep = 0; m_ovr = 0; m_id = '0;
    endtask

    task automatic model_step();
        logic [3:0] rise, rset;
        int nr[4];
        bit tick, ovr;
        int sel, cleared;
        tick = (m_cnt == DV - 1);
        m_cnt = tick ? 0 : m_cnt + 1;
        m_ticked = tick;
        rise = '0; rset = '0;
        if (tick) begin
            for (int i = 0; i < 4; i++) begin
                nr[i] = btn[i] ? ((m_run[i] < 3) ? m_run[i] + 1 : 3) : 0;
                rise[i] = (nr[i] == 3) && (m_run[i] < 3);
            end
            if (rise != 0) begin
                m_active = 1; m_held = 0; m_btn = lowest(rise);
            end else if (m_active) begin
                if (nr[m_btn] < 3 || !repeat_en) m_active = 0;
                else begin
                    m_held++;
                    if (m_held >= RD && (m_held - RD) % RR == 0) rset[m_btn] = 1'b1;
                end
            end
            for (int i = 0; i < 4; i++) m_run[i] = nr[i];
        end
        cleared = -1;
        if ((!m_v || ev_ready) && m_pend != 0) begin
            sel = lowest(m_pend);
            m_v = 1; m_id = 2'(sel); m_rep = m_rflag[sel];
            m_pend[sel] = 1'b0; cleared = sel;
        end else if (m_v && ev_ready) m_v = 0;
        ovr = 0;
        for (int i = 0; i < 4; i++) begin
            if (rise[i] || rset[i]) begin
                if (m_pend[i]) ovr = 1;
                m_pend[i] = 1'b1;
                m_rflag[i] = rset[i];
            end
        end
        m_ovr = ovr;
    endtask

    task automatic cycle();
        logic [3:0] ml;
        @(posedge clk);
        if (!clr) model_step();
        @(negedge clk);
        cyc++;
        for (int i = 0; i < 4; i++) ml[i] = (m_run[i] >= 3);
        chk("model", {level, ev_valid, ev_id, ev_repeat, overrun}, {ml, m_v, m_id, m_rep, m_ovr});
        if (ev_valid === 1'b1) begin
            n_valid++;
            ev_log.push_back('{cyc, ev_id, ev_repeat});
        end
        if (overrun === 1'b1) n_ovr++;
        if (level[1] === 1'b1) n_lvl1++;
    endtask

    task automatic run_ticks(input int n);
        int guard;
        for (int k = 0; k < n; k++) begin
            guard = 0;
            do begin cycle(); guard++; end while (!m_ticked && guard < 4 * DV);
            if (!m_ticked) chk("tick_timeout", 0, 1);
        end
    endtask

    task automatic do_reset();
        clr = 1'b1;
        #1;
        chk("reset_outputs", {level, ev_valid, ev_id, ev_repeat, overrun}, '0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        clr = 1'b0;
        cyc = 0; n_valid = 0; n_ovr = 0; n_lvl1 = 0;
        ev_log.delete();
    endtask

    initial begin
        pv[0] = '{11, 4'b0000, 1'b0, 2'd0, 1'b0};
        pv[1] = '{12, 4'b0100, 1'b0, 2'd0, 1'b0};
        pv[2] = '{13, 4'b0100, 1'b1, 2'd2, 1'b0};
        pv[3] = '{14, 4'b0100, 1'b0, 2'd2, 1'b0};
        pv[4] = '{20, 4'b0100, 1'b0, 2'd2, 1'b0};
        exp_rep[0] = '{13, 2'd2, 1'b0};
        exp_rep[1] = '{25, 2'd2, 1'b1};
        exp_rep[2] = '{33, 2'd2, 1'b1};
        exp_rep[3] = '{41, 2'd2, 1'b1};

        clr = 1'b1; btn = '0; ev_ready = 1'b0; repeat_en = 1'b0;
        model_reset();
        @(negedge clk);

        // Press and handshake
        btn = 4'b0100; ev_ready = 1'b1;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            while (cyc < pv[k].cyc) cycle();
            chk("press_vec", {level, ev_valid, ev_id, ev_repeat},
                {pv[k].lvl, pv[k].v, pv[k].id, pv[k].rep});
        end
        btn = '0;
        run_ticks(2);

        // Bounce rejection on button 1
        do_reset();
        begin
            logic [5:0] pat;
            pat = 6'b011011;
            for (int k = 0; k < 6; k++) begin
                btn = {2'b00, pat[k], 1'b0};
                run_ticks(1);
            end
        end
        btn = '0;
        run_ticks(3);
        chk("bounce_level", n_lvl1, 0);
        chk("bounce_event", n_valid, 0);
        chk("bounce_overrun", n_ovr, 0);

        // Simultaneous press with consumer stalled
        btn = 4'b1001; ev_ready = 1'b0;
        do_reset();
        while (cyc < 12) cycle();
        for (int k = 0; k < 20; k++) begin
            cycle();
            chk("simul_hold", {ev_valid, ev_id}, {1'b1, 2'd0});
        end
        ev_ready = 1'b1;
        cycle();
        chk("simul_second", {ev_valid, ev_id}, {1'b1, 2'd3});
        cycle();
        chk("simul_drain", ev_valid, 0);
        btn = '0;
        run_ticks(2);

        // Overrun: button 0 occupies the output, button 1 pressed twice
        ev_ready = 1'b0;
        btn = 4'b0001;
        do_reset();
        run_ticks(3);
        btn = 4'b0010; run_ticks(3);
        btn = 4'b0000; run_ticks(1);
        btn = 4'b0010; run_ticks(3);
        btn = 4'b0000; run_ticks(2);
        chk("overrun_count", n_ovr, 1);
        chk("overrun_hold", {ev_valid, ev_id}, {1'b1, 2'd0});
        ev_ready = 1'b1;
        cycle();
        chk("overrun_pending", {ev_valid, ev_id, ev_repeat}, {1'b1, 2'd1, 1'b0});
        n_valid = 0;
        for (int k = 0; k < 6; k++) cycle();
        chk("overrun_single", n_valid, 0);

        // Auto-repeat
        repeat_en = 1'b1; ev_ready = 1'b1; btn = 4'b0100;
        do_reset();
        while (cyc < 44) cycle();
        btn = '0;
        while (cyc < 70) cycle();
        chk("repeat_count", ev_log.size(), 4);
        for (int k = 0; k < 4 && k < ev_log.size(); k++)
            chk("repeat_event", {ev_log[k].cyc[15:0], ev_log[k].id, ev_log[k].rep},
                {exp_rep[k].cyc[15:0], exp_rep[k].id, exp_rep[k].rep});

        // Reset while held in the repeat phase
        ev_ready = 1'b0; btn = 4'b0100;
        do_reset();
        while (cyc < 30) cycle();
        chk("midhold_pre", {level, ev_valid}, {4'b0100, 1'b1});
        do_reset();
        ev_ready = 1'b1;
        while (cyc < 16) cycle();
        chk("midhold_count", ev_log.size(), 1);
        if (ev_log.size() > 0)
            chk("midhold_event", {ev_log[0].cyc[15:0], ev_log[0].id, ev_log[0].rep},
                {16'd13, 2'd2, 1'b0});

        // Randomized stimulus against the model
        btn = '0;
        do_reset();
        for (int k = 0; k < 4000; k++) begin
            int flip_range;
            flip_range = ((k / 256) % 2 == 0) ? 15 : 63;
            for (int i = 0; i < 4; i++)
                if ($urandom_range(0, flip_range) == 0) btn[i] = ~btn[i];
            ev_ready = ($urandom_range(0, 3) != 0) && ((k / 512) % 3 != 2);
            if ($urandom_range(0, 199) == 0) repeat_en = ~repeat_en;
            if ($urandom_range(0, 799) == 0) do_reset();
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
